// File: rtl/counter_read_ctrl_pkg.sv
// rtl/counter_read_ctrl_pkg.sv - shared widths, timeout and FSM encoding for the counter read-out sequencer
package counter_read_ctrl_pkg;

  localparam int NUM_CNT = 5;
  localparam int IDX_W   = 3;
  localparam int DATA_W  = 5;
  localparam int TIMEOUT = 15;
  localparam int WAIT_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_WAIT_START = 2'd0,
    S_REQ        = 2'd1,
    S_GAP        = 2'd2,
    S_DONE       = 2'd3
  } state_t;

endpackage

// File: rtl/counter_read_ctrl_if.sv
// rtl/counter_read_ctrl_if.sv - request/response bus between the sequencer and the pop counters
interface counter_read_ctrl_if
  import counter_read_ctrl_pkg::*;
();

  logic              req;
  logic [IDX_W-1:0]  idx;
  logic              valid;
  logic [DATA_W-1:0] data_out;

  modport master (output req, output idx, input valid, input data_out);
  modport slave  (input req, input idx, output valid, output data_out);

endinterface

// File: rtl/counter_read_ctrl_next_idx_sel.sv
// rtl/counter_read_ctrl_next_idx_sel.sv - priority encoder picking the lowest pending counter index
module counter_read_ctrl_next_idx_sel
  import counter_read_ctrl_pkg::*;
(
  input  logic [NUM_CNT-1:0] pending,
  output logic [IDX_W-1:0]   sel_idx,
  output logic               any_left
);

  // Scan downwards so the lowest set bit is the last (winning) assignment.
  always_comb begin
    sel_idx  = '0;
    any_left = |pending;
    for (int i = NUM_CNT - 1; i >= 0; i--) begin
      if (pending[i]) sel_idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/counter_read_ctrl.sv
// rtl/counter_read_ctrl.sv - scans selected pop counters one by one and collects their counts
module counter_read_ctrl
  import counter_read_ctrl_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset_L,
  input  logic                      start,
  input  logic [NUM_CNT-1:0]        rd_mask,
  input  logic                      IDLE,
  counter_read_ctrl_if.master       cnt,
  output logic [NUM_CNT*DATA_W-1:0] counts_out,
  output logic                      busy,
  output logic                      done,
  output logic [NUM_CNT-1:0]        err_to,
  output logic                      err_abort
);

  state_t              state, state_nxt;
  logic [NUM_CNT-1:0]  pending;
  logic [NUM_CNT-1:0]  enc_in;
  logic [IDX_W-1:0]    idx_q;
  logic [IDX_W-1:0]    sel_idx;
  logic                any_left;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [DATA_W-1:0]   slot_q [NUM_CNT];
  logic                accept, capture, timeout, abort, load_req;

  // While waiting, look ahead at the incoming mask so idx is ready on the first req cycle.
  assign enc_in = (state == S_WAIT_START) ? rd_mask : pending;

  counter_read_ctrl_next_idx_sel u_sel (
    .pending  (enc_in),
    .sel_idx  (sel_idx),
    .any_left (any_left)
  );

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) state <= S_WAIT_START;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    timeout   = 1'b0;
    abort     = 1'b0;
    case (state)
      S_WAIT_START: begin
        if (start && IDLE) begin
          accept    = 1'b1;
          state_nxt = (rd_mask == '0) ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        capture = cnt.valid;
        timeout = !cnt.valid && (wait_cnt == WAIT_W'(TIMEOUT - 1));
        abort   = !IDLE;
        if (abort)                   state_nxt = S_DONE;
        else if (capture || timeout) state_nxt = S_GAP;
      end
      S_GAP: begin
        abort = !IDLE;
        if (abort)         state_nxt = S_DONE;
        else if (any_left) state_nxt = S_REQ;
        else               state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_WAIT_START;
      default: state_nxt = S_WAIT_START;
    endcase
  end

  assign load_req = (state_nxt == S_REQ) && (state != S_REQ);

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      pending   <= '0;
      idx_q     <= '0;
      wait_cnt  <= '0;
      err_to    <= '0;
      err_abort <= 1'b0;
      for (int i = 0; i < NUM_CNT; i++) slot_q[i] <= '0;
    end else begin
      if (load_req) begin
        idx_q    <= sel_idx;
        wait_cnt <= '0;
      end else if (state == S_REQ) begin
        wait_cnt <= wait_cnt + 1'b1;
      end

      if (accept) begin
        pending   <= rd_mask;
        err_abort <= 1'b0;
        for (int i = 0; i < NUM_CNT; i++) begin
          if (rd_mask[i]) begin
            slot_q[i] <= '0;
            err_to[i] <= 1'b0;
          end
        end
      end

      // An abort overrides a coincident timeout; a coincident capture is still kept.
      for (int i = 0; i < NUM_CNT; i++) begin
        if (idx_q == IDX_W'(i)) begin
          if (capture) slot_q[i] <= cnt.data_out;
          if (capture || (timeout && !abort)) pending[i] <= 1'b0;
          if (timeout && !abort) err_to[i] <= 1'b1;
        end
      end

      if (abort) err_abort <= 1'b1;
    end
  end

  assign cnt.req = (state == S_REQ);
  assign cnt.idx = idx_q;
  assign busy    = (state != S_WAIT_START);
  assign done    = (state == S_DONE);

  for (genvar g = 0; g < NUM_CNT; g++) begin : g_pack
    assign counts_out[g*DATA_W +: DATA_W] = slot_q[g];
  end

endmodule
